// File: rtl/ctrl_pipe.sv
// rtl/ctrl_pipe.sv - pipeline control: stage registers, hazard stall, branch flush, forwarding select
//
// Purpose:
//   Carries decoder control bundles through ID->EX->MEM->WB. It detects load-use
//   hazards (stall), resolves branches in EX (pc_src/flush), selects EX operand
//   forwarding sources, and counts stall/flush events with saturating counters.
//
// Ports:
//   clk, rstn                   clock, asynchronous active-low reset
//   id_ex/id_m/id_wb            decoder bundles for the instruction in ID
//   id_valid, id_rs1/rs2/rd     ID valid bit and register indices
//   hold                        freeze all registers and counters
//   ex_zero                     ALU zero flag for the instruction in EX
//   ex_* / mem_* / wb_*         registered stage contents
//   stall, pc_src, flush        combinational hazard/branch controls
//   fwd_a, fwd_b                EX operand source (00 regfile, 10 MEM, 01 WB)
//   stall_cnt, flush_cnt        saturating event counters

module ctrl_pipe (
  input  logic        clk,
  input  logic        rstn,
  input  logic [4:0]  id_ex,
  input  logic [2:0]  id_m,
  input  logic [2:0]  id_wb,
  input  logic        id_valid,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic [4:0]  id_rd,
  input  logic        hold,
  input  logic        ex_zero,
  output logic [4:0]  ex_ctrl,
  output logic [2:0]  ex_m,
  output logic [2:0]  ex_wb,
  output logic [4:0]  ex_rd,
  output logic        ex_valid,
  output logic [2:0]  mem_m,
  output logic [2:0]  mem_wb,
  output logic [4:0]  mem_rd,
  output logic        mem_valid,
  output logic [2:0]  wb_wb,
  output logic [4:0]  wb_rd,
  output logic        wb_valid,
  output logic        stall,
  output logic        pc_src,
  output logic        flush,
  output logic [1:0]  fwd_a,
  output logic [1:0]  fwd_b,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
);

  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  // EX stage
  logic        ex_valid_q, ex_valid_d;
  logic [4:0]  ex_ctrl_q,  ex_ctrl_d;
  logic [2:0]  ex_m_q,     ex_m_d;
  logic [2:0]  ex_wb_q,    ex_wb_d;
  logic [4:0]  ex_rd_q,    ex_rd_d;
  logic [4:0]  ex_rs1_q,   ex_rs1_d;
  logic [4:0]  ex_rs2_q,   ex_rs2_d;
  // MEM stage
  logic        mem_valid_q, mem_valid_d;
  logic [2:0]  mem_m_q,     mem_m_d;
  logic [2:0]  mem_wb_q,    mem_wb_d;
  logic [4:0]  mem_rd_q,    mem_rd_d;
  // WB stage
  logic        wb_valid_q, wb_valid_d;
  logic [2:0]  wb_wb_q,    wb_wb_d;
  logic [4:0]  wb_rd_q,    wb_rd_d;
  // counters
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;

  logic branch_taken;
  logic load_use;
  logic stall_int;
  logic ex_bubble;

  // MEM result wins over WB result; x0 is never a forwarding source.
  function automatic logic [1:0] fwd_sel(
    input logic [4:0] rs,
    input logic       m_valid,
    input logic       m_regw,
    input logic [4:0] m_rd,
    input logic       w_valid,
    input logic       w_regw,
    input logic [4:0] w_rd
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (m_valid && m_regw && (m_rd != 5'd0) && (m_rd == rs)) begin
      sel = 2'b10;
    end else if (w_valid && w_regw && (w_rd != 5'd0) && (w_rd == rs)) begin
      sel = 2'b01;
    end
    return sel;
  endfunction

  always_comb begin
    // b_type=1 (beq) takes on zero, b_type=0 (bne) takes on non-zero
    branch_taken = ex_valid_q & ex_m_q[2] & (ex_m_q[1] ? ex_zero : ~ex_zero);
    load_use     = ex_valid_q & ex_wb_q[2] & (ex_wb_q[1:0] == 2'b11) &
                   (ex_rd_q != 5'd0) & id_valid &
                   ((ex_rd_q == id_rs1) | (ex_rd_q == id_rs2));
    // A taken branch squashes the dependent instruction anyway, so it wins.
    stall_int    = load_use & ~branch_taken;
    ex_bubble    = stall_int | branch_taken | ~id_valid;
  end

  always_comb begin
    ex_valid_d  = ex_valid_q;
    ex_ctrl_d   = ex_ctrl_q;
    ex_m_d      = ex_m_q;
    ex_wb_d     = ex_wb_q;
    ex_rd_d     = ex_rd_q;
    ex_rs1_d    = ex_rs1_q;
    ex_rs2_d    = ex_rs2_q;
    mem_valid_d = mem_valid_q;
    mem_m_d     = mem_m_q;
    mem_wb_d    = mem_wb_q;
    mem_rd_d    = mem_rd_q;
    wb_valid_d  = wb_valid_q;
    wb_wb_d     = wb_wb_q;
    wb_rd_d     = wb_rd_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;

    if (!hold) begin
      wb_valid_d  = mem_valid_q;
      wb_wb_d     = mem_wb_q;
      wb_rd_d     = mem_rd_q;

      mem_valid_d = ex_valid_q;
      mem_m_d     = ex_m_q;
      mem_wb_d    = ex_wb_q;
      mem_rd_d    = ex_rd_q;

      // An invalid ID slot is also loaded as a clean all-zero bubble.
      if (ex_bubble) begin
        ex_valid_d = 1'b0;
        ex_ctrl_d  = 5'd0;
        ex_m_d     = 3'd0;
        ex_wb_d    = 3'd0;
        ex_rd_d    = 5'd0;
        ex_rs1_d   = 5'd0;
        ex_rs2_d   = 5'd0;
      end else begin
        ex_valid_d = 1'b1;
        ex_ctrl_d  = id_ex;
        ex_m_d     = id_m;
        ex_wb_d    = id_wb;
        ex_rd_d    = id_rd;
        ex_rs1_d   = id_rs1;
        ex_rs2_d   = id_rs2;
      end

      if (stall_int && (stall_cnt_q != CNT_MAX)) begin
        stall_cnt_d = stall_cnt_q + 16'd1;
      end
      if (branch_taken && (flush_cnt_q != CNT_MAX)) begin
        flush_cnt_d = flush_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ex_valid_q  <= 1'b0;
      ex_ctrl_q   <= 5'd0;
      ex_m_q      <= 3'd0;
      ex_wb_q     <= 3'd0;
      ex_rd_q     <= 5'd0;
      ex_rs1_q    <= 5'd0;
      ex_rs2_q    <= 5'd0;
      mem_valid_q <= 1'b0;
      mem_m_q     <= 3'd0;
      mem_wb_q    <= 3'd0;
      mem_rd_q    <= 5'd0;
      wb_valid_q  <= 1'b0;
      wb_wb_q     <= 3'd0;
      wb_rd_q     <= 5'd0;
      stall_cnt_q <= 16'd0;
      flush_cnt_q <= 16'd0;
    end else begin
      ex_valid_q  <= ex_valid_d;
      ex_ctrl_q   <= ex_ctrl_d;
      ex_m_q      <= ex_m_d;
      ex_wb_q     <= ex_wb_d;
      ex_rd_q     <= ex_rd_d;
      ex_rs1_q    <= ex_rs1_d;
      ex_rs2_q    <= ex_rs2_d;
      mem_valid_q <= mem_valid_d;
      mem_m_q     <= mem_m_d;
      mem_wb_q    <= mem_wb_d;
      mem_rd_q    <= mem_rd_d;
      wb_valid_q  <= wb_valid_d;
      wb_wb_q     <= wb_wb_d;
      wb_rd_q     <= wb_rd_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign ex_ctrl   = ex_ctrl_q;
  assign ex_m      = ex_m_q;
  assign ex_wb     = ex_wb_q;
  assign ex_rd     = ex_rd_q;
  assign ex_valid  = ex_valid_q;
  assign mem_m     = mem_m_q;
  assign mem_wb    = mem_wb_q;
  assign mem_rd    = mem_rd_q;
  assign mem_valid = mem_valid_q;
  assign wb_wb     = wb_wb_q;
  assign wb_rd     = wb_rd_q;
  assign wb_valid  = wb_valid_q;
  assign stall     = stall_int;
  assign pc_src    = branch_taken;
  assign flush     = branch_taken;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

  assign fwd_a = fwd_sel(ex_rs1_q, mem_valid_q, mem_wb_q[2], mem_rd_q,
                         wb_valid_q, wb_wb_q[2], wb_rd_q);
  assign fwd_b = fwd_sel(ex_rs2_q, mem_valid_q, mem_wb_q[2], mem_rd_q,
                         wb_valid_q, wb_wb_q[2], wb_rd_q);

endmodule

// File: doc/ctrl_pipe.md
CTRL_PIPE -- requirements
Module: ctrl_pipe

Interface
REQ-001 clk  in  1  rising-edge clock for all state.
REQ-002 rstn  in  1  reset, asynchronous, active-low.
REQ-003 id_ex  in  5  decoder EX bundle {alu_src_b, alu_op[3:0]}.
REQ-004 id_m  in  3  decoder MEM bundle {branch, b_type, mem_write}; b_type=1 means beq, b_type=0 means bne.
REQ-005 id_wb  in  3  decoder WB bundle {reg_write, mem_to_reg[1:0]}; mem_to_reg=2'b11 marks a load.
REQ-006 id_valid  in  1  the ID stage holds a real instruction.
REQ-007 id_rs1, id_rs2, id_rd  in  5 each  ID register indices.
REQ-008 hold  in  1  external freeze; when high, all stage registers and counters keep their values.
REQ-009 ex_zero  in  1  ALU zero flag of the instruction in EX.
REQ-010 ex_ctrl  out  5  registered copy of id_ex; ex_m and ex_wb are out 3 each; ex_rd is out 5; ex_valid is out 1.
REQ-011 mem_m, mem_wb  out  3 each; mem_rd  out  5; mem_valid  out  1  MEM-stage copies.
REQ-012 wb_wb  out  3; wb_rd  out  5; wb_valid  out  1  WB-stage copies.
REQ-013 stall  out  1  freeze PC and IF/ID this cycle (combinational).
REQ-014 pc_src  out  1  branch taken; select the branch target (combinational).
REQ-015 flush  out  1  squash IF/ID (combinational; equals pc_src).
REQ-016 fwd_a, fwd_b  out  2 each  EX operand source: 2'b00 register file, 2'b10 MEM result, 2'b01 WB result.
REQ-017 stall_cnt, flush_cnt  out  16 each  saturating event counters.

Function
REQ-018 Stages: ID->EX->MEM->WB, one register per stage boundary; each stage carries its control bundles, rd, rs1/rs2 (EX only) and a valid bit.
REQ-019 A bubble is valid=0 with all bundles and rd equal to zero.
REQ-020 Only valid stages may assert stall, pc_src, fwd or counter events.
REQ-021 Branch taken = ex_valid & ex_m[2] & (ex_m[1] ? ex_zero : ~ex_zero); pc_src and flush follow it in the same cycle.
REQ-022 Load-use condition: ex_valid & ex_wb[2] & ex_wb[1:0]==2'b11 & ex_rd!=0 & id_valid & (ex_rd==id_rs1 | ex_rd==id_rs2).
REQ-023 stall = load-use & ~taken; a taken branch overrides a load-use stall.
REQ-024 On each non-hold edge, EX receives a bubble when stall or taken is high; otherwise EX receives the ID contents. MEM<-EX and WB<-MEM always advance.
REQ-025 Load-use latency: exactly one stall cycle per load-use hazard, after which the load is in MEM and forwarding resolves the dependency.
REQ-026 Forwarding for fwd_a (compare ex_rs1) and fwd_b (compare ex_rs2):
- 2'b10 if mem_valid & mem_wb[2] & mem_rd!=0 & mem_rd==ex_rs.
- Otherwise 2'b01 if wb_valid & wb_wb[2] & wb_rd!=0 & wb_rd==ex_rs.
- Otherwise 2'b00.
- MEM has priority over WB.
REQ-027 x0 is never forwarded and never causes a stall.
REQ-028 While hold=1: stall, pc_src and flush are still computed combinationally, but no register, counter or valid bit changes.
REQ-029 stall_cnt increments by 1 on each non-hold edge where stall=1; flush_cnt does the same where pc_src=1. Both saturate at 16'hFFFF with no wrap.
REQ-030 Simultaneous stall and taken: pc_src=1, flush=1, stall=0; flush_cnt increments; stall_cnt does not.

Reset
REQ-031 While rstn=0, asynchronously:
- All valid bits are 0.
- All bundles, rd/rs fields and counters are 0.
- Therefore stall, pc_src, flush = 0 and fwd_a, fwd_b = 2'b00.
REQ-032 Reset asserted mid-stall or mid-branch discards the in-flight instructions. The first edge after release samples ID normally.

Verification
REQ-033 Streaming: addi x1 with id_wb=3'b100, then 3 non-dependent ops -> appears on ex/mem/wb outputs on cycles 1, 2, 3; stall=0, pc_src=0 throughout.
REQ-034 Load-use: lw x5 (id_wb=3'b111), then add with id_rs1=5 -> one cycle with stall=1 and an EX bubble; next cycle fwd_a=2'b10 is not used (load now in MEM), then fwd_a=2'b01 when the load reaches WB; stall_cnt=1.
REQ-035 beq: ex_m=3'b110 with ex_zero=1 -> pc_src=flush=1 that cycle, EX bubble next edge, flush_cnt=1; with ex_zero=0 -> pc_src=0. bne (3'b100) gives the inverse behaviour.
REQ-036 Forward priority: MEM and WB both write x7, EX reads x7 on rs1 and rs2 -> fwd_a=fwd_b=2'b10; with rd=x0 in both -> 2'b00.
REQ-037 Hold and overlap: hold=1 for 3 cycles during a load-use hazard -> outputs frozen and stall_cnt unchanged; separately, a simultaneous load-use and taken branch -> stall=0, pc_src=1.
REQ-038 Saturation and reset: preload flush_cnt=16'hFFFE, take 3 branches -> 16'hFFFF. Then rstn low asynchronously mid-cycle -> all outputs 0 immediately.
